// File: rtl/jpu_bus_arb.sv
// jpu_bus_arb
// ---------------------------------------------------------------------------
// Two-master to one-slave bus arbiter. The instruction-fetch master (i_*) and
// the data master (d_*) share a single memory/MMIO slave port (s_*), which
// lets one unified memory serve both fetch and load/store traffic.
// Only one transaction is ever in flight. Slave-side requests and master-side
// responses all come from flops. A watchdog turns a hung slave into a bus
// error for whichever master owns the bus.
//
// Parameters:
//   AW       word address width (byte address bits [31:2])
//   DW       data width; byte-mask width is DW/8
//   TIMEOUT  cycles to wait for a slave response before erroring; 0 = off
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_req, i_addr            fetch request and word address
//   i_rdata, i_ack, i_err    fetch read data, completion and error pulses
//   d_req, d_we, d_addr,
//   d_wdata, d_mask          data request and its attributes
//   d_rdata, d_ack, d_err    data read data, completion and error pulses
//   s_req, s_we, s_addr,
//   s_wdata, s_mask          slave request and attributes (held while busy)
//   s_rdata, s_ack, s_err    slave read data, completion and error
//   grant_d                  debug: high while the data master owns the bus
//
// Build option:
//   ARB_RR_EN  defined   -> round-robin between masters on contention, the
//                           first contention after reset goes to data
//              undefined -> fixed priority, data always beats fetch
// ---------------------------------------------------------------------------
module jpu_bus_arb #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  // instruction-fetch master
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  output logic            i_err,
  // data master
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_mask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            d_err,
  // shared slave
  output logic            s_req,
  output logic            s_we,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_mask,
  input  logic [DW-1:0]   s_rdata,
  input  logic            s_ack,
  input  logic            s_err,
  // debug
  output logic            grant_d
);

  localparam int MW  = DW / 8;
  // A zero TIMEOUT still needs a legal one-bit counter declaration.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state;
  logic [WDW-1:0] wd_count;
  logic           pick_d;
  logic           timeout_hit;
  logic           respond;
  logic           resp_err;

`ifdef ARB_RR_EN
  // High when the data master should win the next contention.
  logic rr_d;

  always_comb begin
    pick_d = d_req & (~i_req | rr_d);
  end
`else
  always_comb begin
    pick_d = d_req;
  end
`endif

  // wd_count holds the number of busy cycles already spent without a
  // response, so the current busy cycle is the TIMEOUT-th when it equals
  // TIMEOUT-1; s_req is then high for exactly TIMEOUT cycles.
  always_comb begin
    timeout_hit = (TIMEOUT > 0) && (wd_count == WD_LAST);
    respond     = s_err | s_ack | timeout_hit;
    // Without s_ack the only other reasons to respond are s_err or timeout.
    resp_err    = s_err | ~s_ack;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wd_count <= '0;
      s_req    <= 1'b0;
      s_we     <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_mask   <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      grant_d  <= 1'b0;
`ifdef ARB_RR_EN
      rr_d     <= 1'b1;
`endif
    end else begin
      // Response strobes are single-cycle pulses.
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            s_req    <= 1'b1;
            wd_count <= '0;
            if (pick_d) begin
              state   <= BUSY_D;
              grant_d <= 1'b1;
              s_we    <= d_we;
              s_addr  <= d_addr;
              s_wdata <= d_wdata;
              s_mask  <= d_mask;
            end else begin
              // Fetches are always full-word reads.
              state   <= BUSY_I;
              s_we    <= 1'b0;
              s_addr  <= i_addr;
              s_wdata <= '0;
              s_mask  <= {MW{1'b1}};
            end
          end
        end

        BUSY_I, BUSY_D: begin
          if (respond) begin
            s_req   <= 1'b0;
            grant_d <= 1'b0;
            state   <= DONE;
`ifdef ARB_RR_EN
            rr_d    <= (state == BUSY_I);
`endif
            if (state == BUSY_D) begin
              if (resp_err) begin
                d_err <= 1'b1;
              end else begin
                d_ack   <= 1'b1;
                d_rdata <= s_rdata;
              end
            end else begin
              if (resp_err) begin
                i_err <= 1'b1;
              end else begin
                i_ack   <= 1'b1;
                i_rdata <= s_rdata;
              end
            end
          end else if (TIMEOUT > 0) begin
            wd_count <= wd_count + 1'b1;
          end
        end

        // Bubble cycle: requests seen here wait for IDLE.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jpu_bus_arb.sv
// tb_jpu_bus_arb
// ---------------------------------------------------------------------------
// Self-checking bench for jpu_bus_arb (TIMEOUT = 8). A transaction-level
// reference model tracks who owns the bus, how long it has waited and the
// arbitration preference; every falling edge the DUT outputs are compared
// against it. Directed scenarios add literal expectations on top.
// Works with or without ARB_RR_EN defined.
// ---------------------------------------------------------------------------
module tb_jpu_bus_arb;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack, i_err;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [MW-1:0] d_mask;
  logic [DW-1:0] d_rdata;
  logic          d_ack, d_err;
  logic          s_req, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [MW-1:0] s_mask;
  logic [DW-1:0] s_rdata;
  logic          s_ack, s_err;
  logic          grant_d;

  // Slave behaviour knobs
  logic          slave_ack_en;
  logic          slave_err_en;
  logic          late_ack;
  logic [DW-1:0] slave_data;

  int n_vec = 0;
  int n_bad = 0;

  jpu_bus_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_mask  (d_mask),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .d_err   (d_err),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_mask  (s_mask),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .grant_d (grant_d)
  );

  always #5 clk = ~clk;

  // Zero-wait slave: responds in the same cycle it sees s_req.
  assign s_ack   = (s_req & slave_ack_en) | late_ack;
  assign s_err   = s_req & slave_err_en;
  assign s_rdata = slave_data;

  // ---------------- reference model ----------------
  int            m_owner;      // 0 none, 1 fetch, 2 data
  int            m_waited;     // busy cycles spent without a response
  bit            m_cooldown;   // bubble after a completed transaction
  bit            m_prefer_d;
  bit            m_done, m_is_err, m_pick_d;
  logic          e_s_req, e_s_we, e_grant_d;
  logic [AW-1:0] e_s_addr;
  logic [DW-1:0] e_s_wdata, e_i_rdata, e_d_rdata;
  logic [MW-1:0] e_s_mask;
  logic          e_i_ack, e_i_err, e_d_ack, e_d_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_waited = 0; m_cooldown = 0; m_prefer_d = 1;
      e_s_req = 0; e_s_we = 0; e_grant_d = 0;
      e_s_addr = '0; e_s_wdata = '0; e_s_mask = '0;
      e_i_rdata = '0; e_d_rdata = '0;
      e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
    end else begin
      e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
      if (m_owner != 0) begin
        m_done = 0; m_is_err = 0;
        if (s_err) begin
          m_done = 1; m_is_err = 1;
        end else if (s_ack) begin
          m_done = 1;
        end else if (m_waited + 1 >= TO) begin
          m_done = 1; m_is_err = 1;
        end else begin
          m_waited = m_waited + 1;
        end
        if (m_done) begin
          if (m_owner == 1) begin
            if (m_is_err) e_i_err = 1;
            else begin e_i_ack = 1; e_i_rdata = s_rdata; end
          end else begin
            if (m_is_err) e_d_err = 1;
            else begin e_d_ack = 1; e_d_rdata = s_rdata; end
          end
          m_prefer_d = (m_owner == 1);
          m_owner    = 0;
          m_cooldown = 1;
          e_s_req    = 0;
          e_grant_d  = 0;
        end
      end else if (m_cooldown) begin
        m_cooldown = 0;
      end else if (i_req || d_req) begin
`ifdef ARB_RR_EN
        m_pick_d = d_req && (!i_req || m_prefer_d);
`else
        m_pick_d = d_req;
`endif
        m_waited  = 0;
        e_s_req   = 1;
        e_grant_d = m_pick_d;
        if (m_pick_d) begin
          m_owner = 2;
          e_s_we = d_we; e_s_addr = d_addr; e_s_wdata = d_wdata; e_s_mask = d_mask;
        end else begin
          m_owner = 1;
          e_s_we = 0; e_s_addr = i_addr; e_s_wdata = '0; e_s_mask = '1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("s_req",   32'(s_req),   32'(e_s_req));
    checkOutput("s_we",    32'(s_we),    32'(e_s_we));
    checkOutput("s_addr",  32'(s_addr),  32'(e_s_addr));
    checkOutput("s_wdata", s_wdata,      e_s_wdata);
    checkOutput("s_mask",  32'(s_mask),  32'(e_s_mask));
    checkOutput("i_ack",   32'(i_ack),   32'(e_i_ack));
    checkOutput("i_err",   32'(i_err),   32'(e_i_err));
    checkOutput("d_ack",   32'(d_ack),   32'(e_d_ack));
    checkOutput("d_err",   32'(d_err),   32'(e_d_err));
    checkOutput("i_rdata", i_rdata,      e_i_rdata);
    checkOutput("d_rdata", d_rdata,      e_d_rdata);
    checkOutput("grant_d", 32'(grant_d), 32'(e_grant_d));
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dw, input logic [AW-1:0] da,
                               input logic [DW-1:0] dd, input logic [MW-1:0] dm);
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_mask = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  grants[4];
  int  exp_grants[4];
  int  acks;
  int  ngr;
  int  cnt;
  bit  prev_req;

  initial begin
    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, '0, '0, '0);
    slave_ack_en = 0; slave_err_en = 0; late_ack = 0; slave_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_req",   32'(s_req),   0);
    checkOutput("rst_grant_d", 32'(grant_d), 0);
    checkOutput("rst_s_mask",  32'(s_mask),  0);
    rst = 1'b0;

    // Single fetch with a zero-wait slave
    $display("[TB] single fetch");
    slave_ack_en = 1; slave_data = 32'h8C82_0004;
    applyStimulus(1, 30'h100000, 0, 0, '0, '0, '0);
    step();
    checkOutput("fetch_s_req",  32'(s_req),  1);
    checkOutput("fetch_s_addr", 32'(s_addr), 32'h100000);
    checkOutput("fetch_s_mask", 32'(s_mask), 32'hF);
    checkOutput("fetch_s_we",   32'(s_we),   0);
    step();
    checkOutput("fetch_i_ack",   32'(i_ack), 1);
    checkOutput("fetch_i_rdata", i_rdata,    32'h8C82_0004);
    checkOutput("fetch_d_ack",   32'(d_ack), 0);
    applyStimulus(0, 30'h100000, 0, 0, '0, '0, '0);
    step();
    checkOutput("fetch_ack_pulse", 32'(i_ack), 0);

    // Simultaneous requests: data wins first in both builds here
    $display("[TB] contention");
    slave_data = 32'h0000_1111;
    applyStimulus(1, 30'h200, 1, 1, 30'h4000, 32'hBEEF, 4'b0011);
    step();
    checkOutput("cont_grant_d", 32'(grant_d), 1);
    checkOutput("cont_s_we",    32'(s_we),    1);
    checkOutput("cont_s_addr",  32'(s_addr),  32'h4000);
    checkOutput("cont_s_mask",  32'(s_mask),  32'h3);
    checkOutput("cont_s_wdata", s_wdata,      32'hBEEF);
    step();
    checkOutput("cont_d_ack", 32'(d_ack), 1);
    checkOutput("cont_i_ack", 32'(i_ack), 0);
    applyStimulus(1, 30'h200, 0, 0, '0, '0, '0);
    step();
    checkOutput("cont_bubble", 32'(s_req), 0);
    step();
    checkOutput("cont_i_grant",   32'(s_req),   1);
    checkOutput("cont_grant_d_0", 32'(grant_d), 0);
    checkOutput("cont_i_addr",    32'(s_addr),  32'h200);
    step();
    checkOutput("cont_i_ack", 32'(i_ack), 1);
    applyStimulus(0, 30'h200, 0, 0, '0, '0, '0);
    step();

    // Both masters held for four transactions
    $display("[TB] sustained contention");
    applyStimulus(1, 30'h300, 1, 0, 30'h500, '0, 4'hF);
`ifdef ARB_RR_EN
    exp_grants = '{1, 0, 1, 0};
`else
    exp_grants = '{1, 1, 1, 1};
`endif
    grants = '{-1, -1, -1, -1};
    acks = 0; ngr = 0; prev_req = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      step();
      if (s_req && !prev_req && ngr < 4) begin
        grants[ngr] = int'(grant_d);
        ngr++;
      end
      if (i_ack || d_ack) acks++;
      prev_req = s_req;
    end
    applyStimulus(0, 30'h300, 0, 0, '0, '0, '0);
    checkOutput("order_acks", 32'(acks), 4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("order_grant%0d", k), 32'(grants[k]), 32'(exp_grants[k]));
    step();

    // Slave error keeps the previous read data
    $display("[TB] slave error");
    slave_data = 32'hCAFE_F00D;
    applyStimulus(0, '0, 1, 0, 30'h10, '0, 4'hF);
    step();
    step();
    checkOutput("prime_d_ack",   32'(d_ack), 1);
    checkOutput("prime_d_rdata", d_rdata,    32'hCAFE_F00D);
    applyStimulus(0, '0, 0, 0, 30'h10, '0, 4'hF);
    step();
    slave_data = 32'hDEAD_DEAD; slave_err_en = 1;
    applyStimulus(0, '0, 1, 0, 30'h14, '0, 4'hF);
    step();
    step();
    checkOutput("err_d_err",   32'(d_err), 1);
    checkOutput("err_d_ack",   32'(d_ack), 0);
    checkOutput("err_d_rdata", d_rdata,    32'hCAFE_F00D);
    checkOutput("err_i_err",   32'(i_err), 0);
    applyStimulus(0, '0, 0, 0, 30'h14, '0, 4'hF);
    slave_err_en = 0;
    step();

    // Hung slave hits the watchdog
    $display("[TB] timeout");
    slave_ack_en = 0;
    applyStimulus(1, 30'h300, 0, 0, '0, '0, '0);
    step();
    cnt = 0;
    while (s_req && cnt < 20) begin
      cnt++;
      step();
    end
    checkOutput("to_cycles", 32'(cnt),   TO);
    checkOutput("to_i_err",  32'(i_err), 1);
    checkOutput("to_i_ack",  32'(i_ack), 0);
    applyStimulus(0, 30'h300, 0, 0, '0, '0, '0);
    late_ack = 1;
    step();
    checkOutput("late_i_ack", 32'(i_ack), 0);
    checkOutput("late_i_err", 32'(i_err), 0);
    step();
    checkOutput("late_i_ack2", 32'(i_ack), 0);
    checkOutput("late_s_req",  32'(s_req), 0);
    late_ack = 0;

    // Reset in the middle of a data transaction
    $display("[TB] reset mid-op");
    applyStimulus(0, '0, 1, 1, 30'h20, 32'h55, 4'hF);
    step();
    checkOutput("mid_s_req",   32'(s_req),   1);
    checkOutput("mid_grant_d", 32'(grant_d), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_s_req",   32'(s_req),   0);
    checkOutput("async_grant_d", 32'(grant_d), 0);
    checkOutput("async_s_addr",  32'(s_addr),  0);
    applyStimulus(0, '0, 0, 0, '0, '0, '0);
    step();
    checkOutput("rst_hold_d_ack", 32'(d_ack), 0);
    rst = 1'b0;
    slave_ack_en = 1; slave_data = 32'h1234_5678;
    applyStimulus(1, 30'h400, 0, 0, '0, '0, '0);
    step();
    checkOutput("post_s_req", 32'(s_req), 1);
    step();
    checkOutput("post_i_ack",   32'(i_ack), 1);
    checkOutput("post_i_rdata", i_rdata,    32'h1234_5678);
    checkOutput("post_d_ack",   32'(d_ack), 0);
    checkOutput("post_d_err",   32'(d_err), 0);
    applyStimulus(0, 30'h400, 0, 0, '0, '0, '0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
